// File: rtl/isqrt_lut_server.sv
// isqrt_lut_server: RAM-backed inverse-square-root seed table.
// The table is streamed in word by word, followed by a 32-bit checksum word.
// Once the checksum matches, pipeline reads are served with 1-cycle latency.
module isqrt_lut_server #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rom_addr,
   output logic [DATA_W-1:0] rom_dout,
   input  logic              load_start,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_valid,
   output logic              load_ready,
   output logic              table_ready,
   output logic              load_error,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      VERIFY,
      READY
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_count;
   logic [DATA_W-1:0]   r_checksum;
   logic [DATA_W-1:0]   r_dout;
   logic                r_load_ready;
   logic                r_table_ready;
   logic                r_load_error;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_accept;
   logic                w_wr_en;

   // A word is consumed only while ready; load_start in the same cycle discards it.
   assign w_accept = load_valid & r_load_ready & ~load_start;
   assign w_wr_en  = w_accept & (r_state == LOAD);

   // Load/verify state machine with registered status outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!rst) begin
         r_state       <= IDLE;
         r_count       <= '0;
         r_checksum    <= '0;
         r_load_ready  <= 1'b0;
         r_table_ready <= 1'b0;
         r_load_error  <= 1'b0;
      end else if (load_start) begin
         // Restart from any state, including mid-load or mid-verify.
         r_state       <= LOAD;
         r_count       <= '0;
         r_checksum    <= '0;
         r_load_ready  <= 1'b1;
         r_table_ready <= 1'b0;
         r_load_error  <= 1'b0;
      end else begin
         case (r_state)
            LOAD: begin
               if (w_accept) begin
                  r_checksum <= r_checksum + load_data;
                  // Counter is exactly ADDR_W bits, so the last word wraps it to 0.
                  r_count    <= r_count + 1'b1;
                  if (r_count == LAST_ADDR) begin
                     r_state <= VERIFY;
                  end
               end
            end
            VERIFY: begin
               if (w_accept) begin
                  r_load_ready <= 1'b0;
                  if (load_data == r_checksum) begin
                     r_state       <= READY;
                     r_table_ready <= 1'b1;
                     r_load_error  <= 1'b0;
                  end else begin
                     r_state      <= IDLE;
                     r_load_error <= 1'b1;
                  end
               end
            end
            default: begin
               // IDLE and READY only react to load_start, handled above.
            end
         endcase
      end
   end

   // Table write port, driven only while streaming table words.
   always_ff @(posedge clk) begin
      // NOTE: the RAM array has no reset so it maps onto block RAM; its
      // contents are meaningless until a load has been verified anyway.
      if (w_wr_en) begin
         r_mem[r_count] <= load_data;
      end
   end

   // Registered read port: 1-cycle latency, forced to zero unless the table is verified.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_dout <= '0;
      end else if (r_state == READY) begin
         r_dout <= r_mem[rom_addr];
      end else begin
         r_dout <= '0;
      end
   end

   assign rom_dout    = r_dout;
   assign load_ready  = r_load_ready;
   assign table_ready = r_table_ready;
   assign load_error  = r_load_error;
   assign checksum    = r_checksum;

endmodule

// File: tb/tb_isqrt_lut_server.sv
// Directed testbench for isqrt_lut_server: reset, full load and verify,
// checksum failure, back-to-back reads, restart mid-load, reset mid-load.
module tb_isqrt_lut_server;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4096;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_dout;
   logic              load_start;
   logic [DATA_W-1:0] load_data;
   logic              load_valid;
   logic              load_ready;
   logic              table_ready;
   logic              load_error;
   logic [DATA_W-1:0] checksum;

   int n_cmp;
   int n_err;

   isqrt_lut_server #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rom_addr    (rom_addr),
      .rom_dout    (rom_dout),
      .load_start  (load_start),
      .load_data   (load_data),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .table_ready (table_ready),
      .load_error  (load_error),
      .checksum    (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stream n table words, word i = i*mul + add, starting at index first.
   task automatic feed_words(input int first, input int n, input int mul, input int add);
      for (int i = first; i < first + n; i++) begin
         load_valid = 1'b1;
         load_data  = DATA_W'(i * mul + add);
         tick();
      end
      load_valid = 1'b0;
   endtask

   // Full load: start pulse, DEPTH words, then the checksum word.
   task automatic full_load(input int mul, input int add, input logic [DATA_W-1:0] csum);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      feed_words(0, DEPTH, mul, add);
      load_valid = 1'b1;
      load_data  = csum;
      tick();
      load_valid = 1'b0;
      load_data  = '0;
   endtask

   task automatic test_reset();
      rst        = 1'b0;
      rom_addr   = 12'h5A5;
      load_start = 1'b1;
      load_valid = 1'b1;
      load_data  = 32'hCAFE_F00D;
      repeat (3) tick();
      n_cmp++; if (rom_dout !== 32'h0) begin n_err++; $display("FAIL reset_dout: got %h want %h", rom_dout, 32'h0); end
      n_cmp++; if (table_ready !== 1'b0) begin n_err++; $display("FAIL reset_table_ready: got %b want 0", table_ready); end
      n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL reset_load_ready: got %b want 0", load_ready); end
      n_cmp++; if (load_error !== 1'b0) begin n_err++; $display("FAIL reset_load_error: got %b want 0", load_error); end
      n_cmp++; if (checksum !== 32'h0) begin n_err++; $display("FAIL reset_checksum: got %h want %h", checksum, 32'h0); end
      rst        = 1'b1;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      rom_addr   = '0;
      tick();
      // Stray valid in IDLE must be dropped without side effects.
      load_valid = 1'b1;
      load_data  = 32'h1234_5678;
      tick();
      load_valid = 1'b0;
      n_cmp++; if (checksum !== 32'h0) begin n_err++; $display("FAIL idle_drop_checksum: got %h want %h", checksum, 32'h0); end
      n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL idle_load_ready: got %b want 0", load_ready); end
   endtask

   task automatic test_load_ok();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL load_ready_in_load: got %b want 1", load_ready); end
      feed_words(0, DEPTH, 3, 0);
      n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL load_ready_in_verify: got %b want 1", load_ready); end
      n_cmp++; if (table_ready !== 1'b0) begin n_err++; $display("FAIL verify_not_ready: got %b want 0", table_ready); end
      n_cmp++; if (checksum !== 32'h017F_E800) begin n_err++; $display("FAIL load_sum: got %h want %h", checksum, 32'h017F_E800); end
      load_valid = 1'b1;
      load_data  = 32'h017F_E800;
      tick();
      load_valid = 1'b0;
      n_cmp++; if (table_ready !== 1'b1) begin n_err++; $display("FAIL load_table_ready: got %b want 1", table_ready); end
      n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL ready_load_ready: got %b want 0", load_ready); end
      n_cmp++; if (load_error !== 1'b0) begin n_err++; $display("FAIL load_no_error: got %b want 0", load_error); end
      // Valid in READY is ignored: checksum must not move.
      load_valid = 1'b1;
      load_data  = 32'h0000_0100;
      rom_addr   = 12'h00A;
      tick();
      load_valid = 1'b0;
      n_cmp++; if (rom_dout !== 32'h0000_001E) begin n_err++; $display("FAIL rd_00a: got %h want %h", rom_dout, 32'h0000_001E); end
      rom_addr = 12'hFFF;
      tick();
      n_cmp++; if (rom_dout !== 32'h0000_2FFD) begin n_err++; $display("FAIL rd_fff: got %h want %h", rom_dout, 32'h0000_2FFD); end
      rom_addr = 12'h000;
      tick();
      n_cmp++; if (rom_dout !== 32'h0000_0000) begin n_err++; $display("FAIL rd_000: got %h want %h", rom_dout, 32'h0000_0000); end
      n_cmp++; if (checksum !== 32'h017F_E800) begin n_err++; $display("FAIL sum_hold: got %h want %h", checksum, 32'h017F_E800); end
   endtask

   task automatic test_load_bad_checksum();
      full_load(3, 0, 32'h017F_E801);
      n_cmp++; if (load_error !== 1'b1) begin n_err++; $display("FAIL bad_load_error: got %b want 1", load_error); end
      n_cmp++; if (table_ready !== 1'b0) begin n_err++; $display("FAIL bad_table_ready: got %b want 0", table_ready); end
      n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL bad_load_ready: got %b want 0", load_ready); end
      rom_addr = 12'h00A;
      tick();
      n_cmp++; if (rom_dout !== 32'h0) begin n_err++; $display("FAIL bad_rd_00a: got %h want %h", rom_dout, 32'h0); end
   endtask

   task automatic test_back_to_back();
      full_load(3, 0, 32'h017F_E800);
      n_cmp++; if (table_ready !== 1'b1) begin n_err++; $display("FAIL b2b_table_ready: got %b want 1", table_ready); end
      n_cmp++; if (load_error !== 1'b0) begin n_err++; $display("FAIL b2b_error_cleared: got %b want 0", load_error); end
      rom_addr = 12'd1;
      tick();
      n_cmp++; if (rom_dout !== 32'd3) begin n_err++; $display("FAIL b2b_rd1: got %h want %h", rom_dout, 32'd3); end
      rom_addr = 12'd2;
      tick();
      n_cmp++; if (rom_dout !== 32'd6) begin n_err++; $display("FAIL b2b_rd2: got %h want %h", rom_dout, 32'd6); end
      rom_addr = 12'd3;
      tick();
      n_cmp++; if (rom_dout !== 32'd9) begin n_err++; $display("FAIL b2b_rd3: got %h want %h", rom_dout, 32'd9); end
   endtask

   task automatic test_restart();
      // Read issued in the same cycle as load_start still returns table data.
      rom_addr   = 12'd3;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      n_cmp++; if (rom_dout !== 32'd9) begin n_err++; $display("FAIL last_ready_read: got %h want %h", rom_dout, 32'd9); end
      n_cmp++; if (table_ready !== 1'b0) begin n_err++; $display("FAIL restart_not_ready: got %b want 0", table_ready); end
      feed_words(0, 100, 3, 0);
      // 3 * (0+..+99) = 14850
      n_cmp++; if (checksum !== 32'd14850) begin n_err++; $display("FAIL partial_sum: got %h want %h", checksum, 32'd14850); end
      load_start = 1'b1;
      load_valid = 1'b1;
      load_data  = 32'hDEAD_BEEF;
      tick();
      load_start = 1'b0;
      load_valid = 1'b0;
      n_cmp++; if (checksum !== 32'h0) begin n_err++; $display("FAIL restart_sum: got %h want %h", checksum, 32'h0); end
      n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL restart_load_ready: got %b want 1", load_ready); end
      feed_words(0, DEPTH, 3, 0);
      load_valid = 1'b1;
      load_data  = 32'h017F_E800;
      tick();
      load_valid = 1'b0;
      n_cmp++; if (table_ready !== 1'b1) begin n_err++; $display("FAIL restart_verify: got %b want 1", table_ready); end
      rom_addr = 12'hFFF;
      tick();
      n_cmp++; if (rom_dout !== 32'h0000_2FFD) begin n_err++; $display("FAIL restart_rd_fff: got %h want %h", rom_dout, 32'h0000_2FFD); end
   endtask

   task automatic test_reset_mid_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      feed_words(0, 2000, 5, 7);
      rst        = 1'b0;
      load_valid = 1'b1;
      load_data  = 32'd10007;
      tick();
      rst        = 1'b1;
      load_valid = 1'b0;
      n_cmp++; if (rom_dout !== 32'h0) begin n_err++; $display("FAIL midrst_dout: got %h want %h", rom_dout, 32'h0); end
      n_cmp++; if (table_ready !== 1'b0) begin n_err++; $display("FAIL midrst_table_ready: got %b want 0", table_ready); end
      n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL midrst_load_ready: got %b want 0", load_ready); end
      n_cmp++; if (load_error !== 1'b0) begin n_err++; $display("FAIL midrst_load_error: got %b want 0", load_error); end
      n_cmp++; if (checksum !== 32'h0) begin n_err++; $display("FAIL midrst_checksum: got %h want %h", checksum, 32'h0); end
      tick();
      // word i = 5*i + 7: sum = 5*8386560 + 7*4096 = 0x02804800
      full_load(5, 7, 32'h0280_4800);
      n_cmp++; if (table_ready !== 1'b1) begin n_err++; $display("FAIL reload_table_ready: got %b want 1", table_ready); end
      rom_addr = 12'h00A;
      tick();
      n_cmp++; if (rom_dout !== 32'h0000_0039) begin n_err++; $display("FAIL reload_rd_00a: got %h want %h", rom_dout, 32'h0000_0039); end
      rom_addr = 12'hFFF;
      tick();
      n_cmp++; if (rom_dout !== 32'h0000_5002) begin n_err++; $display("FAIL reload_rd_fff: got %h want %h", rom_dout, 32'h0000_5002); end
      rom_addr = 12'h000;
      tick();
      n_cmp++; if (rom_dout !== 32'h0000_0007) begin n_err++; $display("FAIL reload_rd_000: got %h want %h", rom_dout, 32'h0000_0007); end
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      rst        = 1'b0;
      rom_addr   = '0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      #2;
      test_reset();
      test_load_ok();
      test_load_bad_checksum();
      test_back_to_back();
      test_restart();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
